// File: rtl/stack_pkg.sv
// ----------------------------------------------------------------------------
// stack_pkg
// Shared definitions for the dual-stack execution unit:
//   - opcode encodings OP_NOP..OP_NOT
//   - error cause codes ERR_NONE/ERR_DUF/ERR_DOF/ERR_ROF
//   - per-op pop/push counts for the data and return stacks (op_info)
// ----------------------------------------------------------------------------
package stack_pkg;

   localparam int unsigned OP_NOP   = 0;
   localparam int unsigned OP_PUSH  = 1;
   localparam int unsigned OP_DROP  = 2;
   localparam int unsigned OP_DUP   = 3;
   localparam int unsigned OP_SWAP  = 4;
   localparam int unsigned OP_ROT   = 5;
   localparam int unsigned OP_ADD   = 6;
   localparam int unsigned OP_SUB   = 7;
   localparam int unsigned OP_AND   = 8;
   localparam int unsigned OP_OR    = 9;
   localparam int unsigned OP_XOR   = 10;
   localparam int unsigned OP_LT    = 11;
   localparam int unsigned OP_EQ    = 12;
   localparam int unsigned OP_RPUSH = 13;
   localparam int unsigned OP_RPOP  = 14;
   localparam int unsigned OP_RLIT  = 15;
   localparam int unsigned OP_RDROP = 16;
   localparam int unsigned OP_RCOPY = 17;
   localparam int unsigned OP_GT    = 18;
   localparam int unsigned OP_NOT   = 19;

   localparam logic [1:0] ERR_NONE = 2'd0;
   localparam logic [1:0] ERR_DUF  = 2'd1;
   localparam logic [1:0] ERR_DOF  = 2'd2;
   localparam logic [1:0] ERR_ROF  = 2'd3;

   // Entries consumed/produced on each stack. Operand minimum equals the pop
   // count; an op grows a stack when push > pop.
   typedef struct packed {
      logic [1:0] d_pop;
      logic [1:0] d_push;
      logic       r_pop;
      logic       r_push;
   } op_info_t;

   function automatic op_info_t op_info(input int unsigned opc);
      op_info_t i;
      i = '0;
      case (opc)
         OP_PUSH:  i.d_push = 2'd1;
         OP_DROP:  i.d_pop  = 2'd1;
         OP_DUP:   begin i.d_pop = 2'd1; i.d_push = 2'd2; end
         OP_SWAP:  begin i.d_pop = 2'd2; i.d_push = 2'd2; end
         OP_ROT:   begin i.d_pop = 2'd3; i.d_push = 2'd3; end
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_LT, OP_EQ, OP_GT:
                   begin i.d_pop = 2'd2; i.d_push = 2'd1; end
         OP_RPUSH: begin i.d_pop = 2'd1; i.r_push = 1'b1; end
         OP_RPOP:  begin i.r_pop = 1'b1; i.d_push = 2'd1; end
         OP_RLIT:  i.r_push = 1'b1;
         OP_RDROP: i.r_pop  = 1'b1;
         // RCOPY reads rtos without consuming it: pop+push keeps rcnt.
         OP_RCOPY: begin i.r_pop = 1'b1; i.r_push = 1'b1; i.d_push = 2'd1; end
         OP_NOT:   begin i.d_pop = 2'd1; i.d_push = 2'd1; end
         default:  i = '0;
      endcase
      return i;
   endfunction

endpackage

// File: rtl/lifo_mem.sv
// ----------------------------------------------------------------------------
// lifo_mem
// Register-array stack. The caller supplies the complete next occupancy and up
// to NR words to write just below the new top; reads expose the top NR entries
// of the current contents (0 when an entry is absent).
// Ports:
//   clk, rst_n        clock, async active-low reset (clears occupancy only)
//   we_i              commit cnt_d_i and enabled writes this cycle
//   cnt_d_i           next occupancy
//   wr_en_i/wr_data_i write slot k lands at position cnt_d_i-1-k
//   cnt_o             current occupancy
//   rd_o[k]           entry k below the top (k=0 is top)
// ----------------------------------------------------------------------------
module lifo_mem #(
   parameter int W     = 16,
   parameter int DEPTH = 32,
   parameter int NR    = 3
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           we_i,
   input  logic [$clog2(DEPTH+1)-1:0]     cnt_d_i,
   input  logic [NR-1:0]                  wr_en_i,
   input  logic [W-1:0]                   wr_data_i [NR],
   output logic [$clog2(DEPTH+1)-1:0]     cnt_o,
   output logic [W-1:0]                   rd_o [NR]
);
   localparam int CW = $clog2(DEPTH+1);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    cnt_q <= '0;
      else if (we_i) cnt_q <= cnt_d_i;
   end

   // Storage is deliberately unreset; only occupancy defines valid entries.
   always_ff @(posedge clk) begin
      if (we_i) begin
         for (int k = 0; k < NR; k++) begin
            if (wr_en_i[k]) mem_q[AW'(cnt_d_i - CW'(k + 1))] <= wr_data_i[k];
         end
      end
   end

   generate
      for (genvar gi = 0; gi < NR; gi++) begin : g_rd
         logic [CW-1:0] ridx;
         assign ridx     = cnt_q - CW'(gi + 1);
         assign rd_o[gi] = (cnt_q > CW'(gi)) ? mem_q[AW'(ridx)] : '0;
      end
   endgenerate

   assign cnt_o = cnt_q;

endmodule

// File: rtl/stack_engine.sv
// ----------------------------------------------------------------------------
// stack_engine
// Dual-stack execution unit: data stack + return stack with a small ALU on the
// top of the data stack. One op per op_valid/op_ready handshake, one cycle
// each. Illegal ops (under/overflow) are dropped and latch a sticky error that
// only err_clr releases.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   op_valid/op_ready    op handshake (op_ready low while in error)
//   op, op_data          opcode and literal for PUSH/RLIT
//   err_clr              leave the error state
//   tos, nos, rtos       stack tops (0 when absent)
//   dcnt, rcnt           occupancies
//   err, err_code        sticky error flag and cause
// ----------------------------------------------------------------------------
module stack_engine
   import stack_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int DEPTH  = 32,
   parameter int RDEPTH = 16,
   parameter int OP_W   = 5
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        op_valid,
   output logic                        op_ready,
   input  logic [OP_W-1:0]             op,
   input  logic [WIDTH-1:0]            op_data,
   input  logic                        err_clr,
   output logic [WIDTH-1:0]            tos,
   output logic [WIDTH-1:0]            nos,
   output logic [WIDTH-1:0]            rtos,
   output logic [$clog2(DEPTH+1)-1:0]  dcnt,
   output logic [$clog2(RDEPTH+1)-1:0] rcnt,
   output logic                        err,
   output logic [1:0]                  err_code
);
   localparam int DCW = $clog2(DEPTH+1);
   localparam int RCW = $clog2(RDEPTH+1);

   typedef enum logic {ST_RUN, ST_ERR} state_e;

   state_e           state_q;
   logic             op_ready_q, err_q;
   logic [1:0]       err_code_q;

   logic [WIDTH-1:0] d_rd [3];
   logic [WIDTH-1:0] r_rd [1];
   logic [WIDTH-1:0] d_wd [3];
   logic [WIDTH-1:0] r_wd [1];
   logic [2:0]       d_we;
   logic [0:0]       r_we;
   logic [DCW-1:0]   dcnt_d;
   logic [RCW-1:0]   rcnt_d;

   int unsigned      opc;
   op_info_t         info;
   logic             fire, exec;
   logic [1:0]       viol;
   logic [WIDTH-1:0] alu_res;

   always_comb begin
      opc  = 32'(op);
      info = op_info(opc);
   end

   // Legality: data underflow, then data overflow, then return-stack faults.
   always_comb begin
      viol = ERR_NONE;
      if (dcnt < DCW'(info.d_pop))
         viol = ERR_DUF;
      else if ((info.d_push > info.d_pop) && (dcnt == DCW'(DEPTH)))
         viol = ERR_DOF;
      else if ((rcnt < RCW'(info.r_pop)) ||
               (info.r_push && !info.r_pop && (rcnt == RCW'(RDEPTH))))
         viol = ERR_ROF;
   end

   assign fire   = op_valid && op_ready_q;
   assign exec   = fire && (viol == ERR_NONE);
   assign dcnt_d = dcnt - DCW'(info.d_pop) + DCW'(info.d_push);
   assign rcnt_d = rcnt - RCW'(info.r_pop) + RCW'(info.r_push);

   // ALU: NOS is the left operand for SUB and comparisons.
   always_comb begin
      alu_res = '0;
      case (opc)
         OP_ADD: alu_res = d_rd[1] + d_rd[0];
         OP_SUB: alu_res = d_rd[1] - d_rd[0];
         OP_AND: alu_res = d_rd[1] & d_rd[0];
         OP_OR:  alu_res = d_rd[1] | d_rd[0];
         OP_XOR: alu_res = d_rd[1] ^ d_rd[0];
         OP_LT:  alu_res = (d_rd[1] <  d_rd[0]) ? '1 : '0;
         OP_EQ:  alu_res = (d_rd[1] == d_rd[0]) ? '1 : '0;
         OP_GT:  alu_res = (d_rd[1] >  d_rd[0]) ? '1 : '0;
         default: alu_res = '0;
      endcase
   end

   // Writes are expressed relative to the new top, so the lifo never needs to
   // know which op ran.
   always_comb begin
      d_we = '0;
      r_we = '0;
      for (int k = 0; k < 3; k++) d_wd[k] = '0;
      r_wd[0] = '0;
      case (opc)
         OP_PUSH:  begin d_we = 3'b001; d_wd[0] = op_data; end
         OP_DUP:   begin d_we = 3'b001; d_wd[0] = d_rd[0]; end
         OP_SWAP:  begin d_we = 3'b011; d_wd[0] = d_rd[1]; d_wd[1] = d_rd[0]; end
         OP_ROT:   begin
            d_we = 3'b111;
            d_wd[0] = d_rd[2]; d_wd[1] = d_rd[0]; d_wd[2] = d_rd[1];
         end
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_LT, OP_EQ, OP_GT:
                   begin d_we = 3'b001; d_wd[0] = alu_res; end
         OP_NOT:   begin d_we = 3'b001; d_wd[0] = ~d_rd[0]; end
         OP_RPOP, OP_RCOPY:
                   begin d_we = 3'b001; d_wd[0] = r_rd[0]; end
         OP_RPUSH: begin r_we = 1'b1; r_wd[0] = d_rd[0]; end
         OP_RLIT:  begin r_we = 1'b1; r_wd[0] = op_data; end
         default:  ;
      endcase
   end

   lifo_mem #(.W(WIDTH), .DEPTH(DEPTH), .NR(3)) u_dstack (
      .clk       (clk),
      .rst_n     (rst_n),
      .we_i      (exec),
      .cnt_d_i   (dcnt_d),
      .wr_en_i   (d_we),
      .wr_data_i (d_wd),
      .cnt_o     (dcnt),
      .rd_o      (d_rd)
   );

   lifo_mem #(.W(WIDTH), .DEPTH(RDEPTH), .NR(1)) u_rstack (
      .clk       (clk),
      .rst_n     (rst_n),
      .we_i      (exec),
      .cnt_d_i   (rcnt_d),
      .wr_en_i   (r_we),
      .wr_data_i (r_wd),
      .cnt_o     (rcnt),
      .rd_o      (r_rd)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_RUN;
         op_ready_q <= 1'b1;
         err_q      <= 1'b0;
         err_code_q <= ERR_NONE;
      end else begin
         case (state_q)
            ST_RUN: if (fire && (viol != ERR_NONE)) begin
               state_q    <= ST_ERR;
               op_ready_q <= 1'b0;
               err_q      <= 1'b1;
               err_code_q <= viol;
            end
            ST_ERR: if (err_clr) begin
               state_q    <= ST_RUN;
               op_ready_q <= 1'b1;
               err_q      <= 1'b0;
               err_code_q <= ERR_NONE;
            end
            default: state_q <= ST_RUN;
         endcase
      end
   end

   assign op_ready = op_ready_q;
   assign err      = err_q;
   assign err_code = err_code_q;
   assign tos      = d_rd[0];
   assign nos      = d_rd[1];
   assign rtos     = r_rd[0];

endmodule

// File: tb/tb_stack_engine.sv
// ----------------------------------------------------------------------------
// tb_stack_engine
// Self-checking bench: a fixed vector table, hand-written corner sequences and
// random traffic, all compared against a queue-based reference model.
// ----------------------------------------------------------------------------
module tb_stack_engine;
   localparam int DEPTH  = 8;
   localparam int RDEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        op_valid = 1'b0;
   logic        op_ready;
   logic [4:0]  op = '0;
   logic [15:0] op_data = '0;
   logic        err_clr = 1'b0;
   logic [15:0] tos, nos, rtos;
   logic [3:0]  dcnt;
   logic [2:0]  rcnt;
   logic        err;
   logic [1:0]  err_code;

   int n_total = 0;
   int n_bad   = 0;

   stack_engine #(.WIDTH(16), .DEPTH(DEPTH), .RDEPTH(RDEPTH), .OP_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
      .op(op), .op_data(op_data), .err_clr(err_clr), .tos(tos), .nos(nos),
      .rtos(rtos), .dcnt(dcnt), .rcnt(rcnt), .err(err), .err_code(err_code)
   );

   always #5 clk = ~clk;

   // ---------------- reference model (index 0 = top) ----------------
   logic [15:0] dq[$];
   logic [15:0] rq[$];
   logic        m_err;
   logic [1:0]  m_code;

   task automatic model_reset();
      dq.delete(); rq.delete(); m_err = 1'b0; m_code = 2'd0;
   endtask

   task automatic model_apply(input logic v, input logic [4:0] o,
                              input logic [15:0] d, input logic clr);
      int dneed, rneed;
      bit dgrow, rgrow;
      logic [15:0] t, n, r;
      if (m_err) begin
         if (clr) begin m_err = 1'b0; m_code = 2'd0; end
         return;
      end
      if (!v) return;
      dneed = 0; rneed = 0; dgrow = 0; rgrow = 0;
      case (o)
         1:  dgrow = 1;
         2:  dneed = 1;
         3:  begin dneed = 1; dgrow = 1; end
         4:  dneed = 2;
         5:  dneed = 3;
         6, 7, 8, 9, 10, 11, 12, 18: dneed = 2;
         13: begin dneed = 1; rgrow = 1; end
         14: begin rneed = 1; dgrow = 1; end
         15: rgrow = 1;
         16: rneed = 1;
         17: begin rneed = 1; dgrow = 1; end
         19: dneed = 1;
         default: ;
      endcase
      if (dq.size() < dneed)                       m_code = 2'd1;
      else if (dgrow && dq.size() == DEPTH)        m_code = 2'd2;
      else if (rq.size() < rneed || (rgrow && rq.size() == RDEPTH)) m_code = 2'd3;
      if (m_code != 2'd0) begin m_err = 1'b1; return; end
      case (o)
         1:  dq.push_front(d);
         2:  void'(dq.pop_front());
         3:  dq.push_front(dq[0]);
         4:  begin t = dq[0]; dq[0] = dq[1]; dq[1] = t; end
         5:  begin t = dq[0]; n = dq[1]; r = dq[2]; dq[0] = r; dq[1] = t; dq[2] = n; end
         6, 7, 8, 9, 10, 11, 12, 18: begin
            t = dq.pop_front(); n = dq.pop_front();
            case (o)
               6:  r = n + t;
               7:  r = n - t;
               8:  r = n & t;
               9:  r = n | t;
               10: r = n ^ t;
               11: r = (n < t)  ? 16'hFFFF : 16'h0;
               12: r = (n == t) ? 16'hFFFF : 16'h0;
               default: r = (n > t) ? 16'hFFFF : 16'h0;
            endcase
            dq.push_front(r);
         end
         13: rq.push_front(dq.pop_front());
         14: dq.push_front(rq.pop_front());
         15: rq.push_front(d);
         16: void'(rq.pop_front());
         17: dq.push_front(rq[0]);
         19: dq[0] = ~dq[0];
         default: ;
      endcase
   endtask

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_model(input string tag);
      chk({tag, ".tos"},  32'(tos),  32'(dq.size() > 0 ? dq[0] : 16'h0));
      chk({tag, ".nos"},  32'(nos),  32'(dq.size() > 1 ? dq[1] : 16'h0));
      chk({tag, ".rtos"}, 32'(rtos), 32'(rq.size() > 0 ? rq[0] : 16'h0));
      chk({tag, ".dcnt"}, 32'(dcnt), dq.size());
      chk({tag, ".rcnt"}, 32'(rcnt), rq.size());
      chk({tag, ".err"},  32'(err),  32'(m_err));
      chk({tag, ".code"}, 32'(err_code), 32'(m_code));
      chk({tag, ".rdy"},  32'(op_ready), 32'(!m_err));
   endtask

   // Drive on the falling edge, let the rising edge act, sample 1 ns later.
   task automatic step(input logic v, input logic [4:0] o, input logic [15:0] d,
                       input logic clr);
      @(negedge clk);
      op_valid = v; op = o; op_data = d; err_clr = clr;
      model_apply(v, o, d, clr);
      @(posedge clk);
      #1;
      $display("op v=%0b op=%0d data=%h clr=%0b -> tos=%h nos=%h rtos=%h dcnt=%0d rcnt=%0d err=%0b code=%0d",
               v, o, d, clr, tos, nos, rtos, dcnt, rcnt, err, err_code);
      op_valid = 1'b0; err_clr = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; op_valid = 1'b0; err_clr = 1'b0;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [4:0]  op;
      logic [15:0] data;
      logic [15:0] tos;
      logic [15:0] nos;
      int          dcnt;
   } vec_t;
   vec_t vt[$];

   task automatic add(input logic [4:0] o, input logic [15:0] d,
                      input logic [15:0] et, input logic [15:0] en, input int ec);
      vec_t x;
      x.op = o; x.data = d; x.tos = et; x.nos = en; x.dcnt = ec;
      vt.push_back(x);
   endtask

   initial begin
      logic       v, clr;
      logic [4:0] o;
      int         r;

      add(1, 16'd5, 16'd5, 16'd0, 1);       add(1, 16'd3, 16'd3, 16'd5, 2);
      add(7, 16'd0, 16'd2, 16'd0, 1);       add(1, 16'd7, 16'd7, 16'd2, 2);
      add(11, 16'd0, 16'hFFFF, 16'd0, 1);   add(2, 16'd0, 16'd0, 16'd0, 0);
      add(1, 16'd1, 16'd1, 16'd0, 1);       add(1, 16'd2, 16'd2, 16'd1, 2);
      add(1, 16'd3, 16'd3, 16'd2, 3);       add(5, 16'd0, 16'd1, 16'd3, 3);
      add(4, 16'd0, 16'd3, 16'd1, 3);       add(2, 16'd0, 16'd1, 16'd2, 2);
      add(2, 16'd0, 16'd2, 16'd0, 1);       add(19, 16'd0, 16'hFFFD, 16'd0, 1);
      add(1, 16'h00F0, 16'h00F0, 16'hFFFD, 2);
      add(8, 16'd0, 16'h00F0, 16'd0, 1);    add(1, 16'h000F, 16'h000F, 16'h00F0, 2);
      add(9, 16'd0, 16'h00FF, 16'd0, 1);    add(1, 16'h00FF, 16'h00FF, 16'h00FF, 2);
      add(12, 16'd0, 16'hFFFF, 16'd0, 1);   add(1, 16'd1, 16'd1, 16'hFFFF, 2);
      add(18, 16'd0, 16'hFFFF, 16'd0, 1);   add(1, 16'h0F0F, 16'h0F0F, 16'hFFFF, 2);
      add(10, 16'd0, 16'hF0F0, 16'd0, 1);   add(1, 16'd1, 16'd1, 16'hF0F0, 2);
      add(6, 16'd0, 16'hF0F1, 16'd0, 1);    add(3, 16'd0, 16'hF0F1, 16'hF0F1, 2);
      add(31, 16'hAAAA, 16'hF0F1, 16'hF0F1, 2);
      add(2, 16'd0, 16'hF0F1, 16'd0, 1);    add(2, 16'd0, 16'd0, 16'd0, 0);

      // Reset state
      do_reset();
      #1;
      check_model("reset");

      foreach (vt[i]) begin
         step(1'b1, vt[i].op, vt[i].data, 1'b0);
         chk($sformatf("vec%0d.tos", i),  32'(tos),  32'(vt[i].tos));
         chk($sformatf("vec%0d.nos", i),  32'(nos),  32'(vt[i].nos));
         chk($sformatf("vec%0d.dcnt", i), 32'(dcnt), vt[i].dcnt);
         chk($sformatf("vec%0d.err", i),  32'(err),  32'd0);
      end

      // Underflow, ignored op while in error, clear with simultaneous op
      do_reset();
      step(1, 2, 0, 0);
      chk("duf.code", 32'(err_code), 32'd1);
      chk("duf.rdy",  32'(op_ready), 32'd0);
      check_model("duf");
      step(1, 1, 16'd9, 0);
      chk("errign.dcnt", 32'(dcnt), 32'd0);
      step(1, 1, 16'd9, 1);
      chk("clr.err",  32'(err), 32'd0);
      chk("clr.dcnt", 32'(dcnt), 32'd0);
      step(0, 0, 0, 1);
      check_model("clr_in_run");
      step(1, 1, 16'd9, 0);
      chk("after_clr.tos", 32'(tos), 32'd9);

      // Data full boundary and overflow
      do_reset();
      for (int i = 0; i < DEPTH; i++) step(1, 1, 16'(i), 0);
      chk("full.dcnt", 32'(dcnt), DEPTH);
      chk("full.err",  32'(err), 32'd0);
      step(1, 3, 0, 0);
      chk("dof.code", 32'(err_code), 32'd2);
      chk("dof.dcnt", 32'(dcnt), DEPTH);
      chk("dof.tos",  32'(tos), DEPTH - 1);
      step(0, 0, 0, 1);
      step(1, 6, 0, 0);
      chk("full_add.dcnt", 32'(dcnt), DEPTH - 1);
      chk("full_add.tos",  32'(tos), (DEPTH - 1) + (DEPTH - 2));
      check_model("full_add");

      // Return stack
      do_reset();
      step(1, 15, 16'h0040, 0);
      step(1, 1, 16'd8, 0);
      step(1, 13, 0, 0);
      chk("rpush.rcnt", 32'(rcnt), 32'd2);
      chk("rpush.rtos", 32'(rtos), 32'h8);
      chk("rpush.dcnt", 32'(dcnt), 32'd0);
      step(1, 14, 0, 0);
      chk("rpop.tos",  32'(tos), 32'h8);
      chk("rpop.rtos", 32'(rtos), 32'h40);
      step(1, 16, 0, 0);
      chk("rdrop.rcnt", 32'(rcnt), 32'd0);
      step(1, 16, 0, 0);
      chk("rduf.code", 32'(err_code), 32'd3);
      step(0, 0, 0, 1);
      for (int i = 0; i < RDEPTH; i++) step(1, 15, 16'(i + 16'h100), 0);
      chk("rfull.err", 32'(err), 32'd0);
      step(1, 15, 16'h0BAD, 0);
      chk("rof.code", 32'(err_code), 32'd3);
      chk("rof.rcnt", 32'(rcnt), RDEPTH);
      check_model("rof");

      // Asynchronous reset between clock edges
      do_reset();
      for (int i = 0; i < 4; i++) step(1, 1, 16'(i + 1), 0);
      chk("pre_arst.dcnt", 32'(dcnt), 32'd4);
      step(1, 16, 0, 0);
      chk("pre_arst.err", 32'(err), 32'd1);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst.dcnt", 32'(dcnt), 32'd0);
      chk("arst.err",  32'(err), 32'd0);
      chk("arst.code", 32'(err_code), 32'd0);
      chk("arst.rdy",  32'(op_ready), 32'd1);
      chk("arst.tos",  32'(tos), 32'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;

      // Random traffic against the model
      for (int i = 0; i < 800; i++) begin
         v   = ($urandom_range(0, 9) < 8);
         r   = $urandom_range(0, 99);
         if (r < 30)      o = 5'd1;
         else if (r < 35) o = 5'd15;
         else if (r < 40) o = 5'($urandom_range(20, 31));
         else             o = 5'($urandom_range(0, 19));
         clr = ($urandom_range(0, 9) == 0);
         step(v, o, 16'($urandom), clr);
         check_model($sformatf("rnd%0d", i));
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/stack_engine.md
Name: stack_engine

Overview:
- Parametrised dual-stack execution unit for the stack CPU: a data stack and a return stack, plus a small ALU that operates on the top of the data stack.
- Replaces the ad-hoc push/pop tasks inside the CPU with a reusable block that has a handshake and configurable width and depths.
- Adds behaviour the current core lacks: overflow/underflow detection, a sticky error state, and stack-pointer/occupancy visibility.
- Sits between the CPU decode FSM (issues one op per handshake) and the instruction-pointer logic (consumes rtos for RET).

Parameters:
- WIDTH, 16, data and return stack word width.
- DEPTH, 32, data stack entries (power of two, >=4).
- RDEPTH, 16, return stack entries (power of two, >=2).
- OP_W, 5, opcode width.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- op_valid  in  1  decoder presents an op.
- op_ready  out  1  engine accepts an op this cycle.
- op  in  OP_W  opcode, encodings held in the shared package.
- op_data  in  WIDTH  literal for PUSH/RLIT.
- err_clr  in  1  clears the error state.
- tos, nos  out  WIDTH  data stack top and second entry; 0 when absent.
- rtos  out  WIDTH  return stack top; 0 when empty.
- dcnt  out  clog2(DEPTH+1)  data stack occupancy.
- rcnt  out  clog2(RDEPTH+1)  return stack occupancy.
- err  out  1  sticky error flag.
- err_code  out  2  error cause: 0 none, 1 data underflow, 2 data overflow, 3 return under/overflow.

Behaviour:
- Reset (async assert, sync release): dcnt=0, rcnt=0, err=0, err_code=0, op_ready=1, tos=nos=rtos=0. Storage contents are don't-care.
- States:
  - RUN: op_ready=1.
  - ERR: op_ready=0, err=1.
- Op fires on op_valid&&op_ready. Every op completes in one cycle; tos/nos/rtos/dcnt/rcnt reflect the result on the next cycle.
- Opcodes and their effect (NOS, ROS = second and third data entries):
  - 0 NOP: no change.
  - 1 PUSH: push op_data.
  - 2 DROP: pop 1.
  - 3 DUP: push TOS.
  - 4 SWAP: exchange TOS and NOS.
  - 5 ROT: TOS<=ROS, NOS<=TOS, ROS<=NOS.
  - 6 ADD, 7 SUB (NOS-TOS), 8 AND, 9 OR, 10 XOR: pop 2, push result, modulo 2^WIDTH.
  - 11 LT, 12 EQ, 18 GT: NOS vs TOS, unsigned; push all-ones if true, else 0.
  - 13 RPUSH: pop TOS, push it to the return stack.
  - 14 RPOP: pop return stack, push the value to the data stack.
  - 15 RLIT: push op_data to the return stack (call link).
  - 16 RDROP: pop the return stack (RET; ip takes rtos in the same cycle).
  - 17 RCOPY: push rtos to the data stack.
  - 19 NOT: TOS <= ~TOS.
  - Other codes: treated as NOP.
- Operand minimums, checked before any state change:
  - DROP/DUP/NOT/RPUSH: dcnt>=1.
  - SWAP and binary ops: dcnt>=2.
  - ROT: dcnt>=3.
  - RPOP/RDROP/RCOPY: rcnt>=1.
- Capacity checks:
  - Net data growth with dcnt==DEPTH is an overflow.
  - RPUSH/RLIT with rcnt==RDEPTH is a return overflow.
- Fault handling:
  - A violating op is not executed: no pointer or storage change.
  - err_code is set, next state is ERR.
  - Data underflow takes priority over overflow. For RPUSH/RPOP, the data-side check is evaluated first.
- ERR state:
  - op_valid is ignored.
  - err_clr returns to RUN next cycle with err=0 and err_code=0. Stack contents and counts are preserved.
  - err_clr in RUN has no effect.
- Simultaneous err_clr and op_valid in ERR: clear only; the op is not accepted that cycle because op_ready=0.
- Exact full/empty boundaries are legal:
  - PUSH at dcnt==DEPTH-1 succeeds, giving dcnt==DEPTH.
  - DROP at dcnt==1 gives dcnt==0, tos=0.
- Binary ops at dcnt==DEPTH are legal (net -1). DUP at dcnt==DEPTH overflows.
- Reset mid-operation: counts clear immediately and asynchronously; any op in flight is lost.

Decomposition:
- Shared package stack_pkg holds:
  - opcode localparams OP_NOP..OP_NOT;
  - err_code values ERR_NONE/ERR_DUF/ERR_DOF/ERR_ROF;
  - per-op pop/push count constants.
- One sub-module, lifo_mem: parametrised register-array stack with top-3 read ports.
  - Instantiated twice: data stack with 3 read ports, return stack using 1 read port.
  - ALU and legality checks live in stack_engine.

Test Plan:
- PUSH 5, PUSH 3, SUB -> tos=2, dcnt=1. Then PUSH 7, LT -> tos=16'hFFFF, dcnt=1.
- PUSH 1,2,3, ROT -> tos=1, nos=3, third=2. SWAP -> tos=3, nos=1.
- Reset, DROP -> err=1, err_code=1, op_ready=0, dcnt=0. PUSH 9 ignored while in ERR. err_clr -> err=0, op_ready=1, dcnt=0.
- DEPTH PUSHes of i -> dcnt=DEPTH, no err. DUP -> err_code=2, dcnt=DEPTH, tos unchanged. err_clr, ADD -> dcnt=DEPTH-1, no err.
- RLIT 16'h0040, PUSH 8, RPUSH -> rcnt=2, rtos=8, dcnt=0. RPOP -> tos=8, rtos=16'h0040. RDROP -> rcnt=0. RDROP again -> err_code=3.
- Assert rst_n low mid-sequence with dcnt=4 -> dcnt=0, err=0 asynchronously, before the next clock edge.
